// File: rtl/seg_display_scheduler_pkg.sv
// seg_display_pkg
// Shared types, constants and helpers for the segment display scheduler.
// Contents: FSM state enum, round-robin grant struct, active-low segment
// codes for digits 0..9 plus blank, display limits, and two helpers
// (BCD-to-segment decode and the round-robin pick).
package seg_display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CONVERT,
        ST_LATCH,
        ST_DWELL
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } grant_t;

    // Segment codes {dp,g,f,e,d,c,b,a}, active-low, decimal point off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [31:0] MAX_DISPLAY = 32'd99_999_999;
    localparam int          NUM_DIGITS  = 8;
    localparam int          BCD_CYCLES  = 32;

    function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // First valid requester searching from cur+1, wrapping, cur itself last.
    // The loop runs from lowest to highest priority so the last hit wins.
    function automatic grant_t rr_pick(input logic [3:0] valid,
                                       input logic [1:0] cur,
                                       input int         n);
        grant_t res;
        int     idx;
        res.found = 1'b0;
        res.idx   = cur;
        for (int k = n; k >= 1; k--) begin
            idx = (int'(cur) + k) % n;
            if (valid[idx[1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_display_scheduler_bin2bcd.sv
// seg_bin2bcd_seq
// Sequential shift-add-3 (double dabble) binary-to-BCD converter, one input
// bit per clock.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   start       load bin and begin converting (restarts a running conversion)
//   bin[31:0]   unsigned binary input, sampled on start
//   done        one-cycle pulse in the 32nd cycle after start
//   bcd[31:0]   8 BCD digits, digit 0 in bcd[3:0]; final from the cycle
//               after done (the last shift lands on the edge ending done)
module seg_bin2bcd_seq
    import seg_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        done,
    output logic [31:0] bcd
);

    logic [31:0] r_bin;
    logic [31:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_run;
    logic [31:0] w_adj;

    // Add 3 to every digit that would reach 10 or more after the shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                    ? r_bcd[4*gi +: 4] + 4'd3
                                    : r_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_bcd <= {w_adj[30:0], r_bin[31]};
            r_bin <= {r_bin[30:0], 1'b0};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(BCD_CYCLES - 1)) begin
                r_run <= 1'b0;
            end
        end
    end

    assign done = r_run && (r_cnt == 5'(BCD_CYCLES - 1));
    assign bcd  = r_bcd;

endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
// Time-shares an 8-digit active-low 7-segment display between NUM_SRC value
// producers: round-robin grant with valid/ack handshake, sequential BCD
// conversion per grant, minimum dwell per source, and a free-running
// anode/cathode scan of the digit buffer.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   src_valid    per-source request
//   src_data     source i value at [32*i+31:32*i]
//   src_ack      one-cycle pulse in the cycle a source's value is captured
//   hold         keep the current source while its dwell has expired
//   cur_src      index of the source currently displayed
//   busy         high in SELECT / CONVERT / LATCH
//   anodo        digit enables, active-low, bit i = digit i
//   catodo       segments {dp,g,f,e,d,c,b,a}, active-low
// Optional: define SEG_SRC_DP_EN to light the decimal point on digit
// index cur_src, marking the active source.
module seg_display_scheduler
    import seg_display_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int SCAN_DIV    = 5000,
    parameter int DWELL_TICKS = 50000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [32*NUM_SRC-1:0]  src_data,
    output logic [NUM_SRC-1:0]     src_ack,
    input  logic                   hold,
    output logic [1:0]             cur_src,
    output logic                   busy,
    output logic [7:0]             anodo,
    output logic [7:0]             catodo
);

    localparam logic [31:0] DWELL_LAST = (DWELL_TICKS <= 1) ? 32'd0 : 32'(DWELL_TICKS - 1);
    localparam logic [31:0] SCAN_LAST  = (SCAN_DIV <= 1) ? 32'd0 : 32'(SCAN_DIV - 1);

    state_t      r_state;
    logic [1:0]  r_cur_src;
    logic        r_busy;
    logic        r_ovf;
    logic [31:0] r_buf;
    logic [31:0] r_dwell;
    logic [31:0] r_scan_cnt;
    logic [2:0]  r_scan_idx;
    logic [7:0]  r_anodo;
    logic [7:0]  r_catodo;

    grant_t      w_grant;
    logic [31:0] w_sel_data;
    logic        w_sel_ovf;
    logic        w_select;
    logic        w_start;
    logic        w_done;
    logic [31:0] w_bcd;
    logic [7:0]  w_seg;
    logic        w_dp_n;

    assign w_grant    = rr_pick(4'(src_valid), r_cur_src, NUM_SRC);
    assign w_sel_data = src_data[int'(w_grant.idx)*32 +: 32];
    assign w_sel_ovf  = w_sel_data > MAX_DISPLAY;
    assign w_select   = (r_state == ST_SELECT) && w_grant.found;
    // Over-range values skip the converter; LATCH substitutes all nines.
    assign w_start    = w_select && !w_sel_ovf;

    // The ack must coincide with the capture edge of SELECT and vanish if
    // the request was withdrawn, so it is decoded from the live grant.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ack
            assign src_ack[gi] = w_select && (w_grant.idx == 2'(gi));
        end
    endgenerate

    seg_bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .bin   (w_sel_data),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cur_src <= '0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_buf     <= '0;
            r_dwell   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|src_valid) begin
                        r_state <= ST_SELECT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (w_grant.found) begin
                        r_cur_src <= w_grant.idx;
                        r_ovf     <= w_sel_ovf;
                        r_state   <= ST_CONVERT;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    if (r_ovf || w_done) begin
                        r_state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_buf   <= r_ovf ? 32'h9999_9999 : w_bcd;
                    r_dwell <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_DWELL;
                end
                ST_DWELL: begin
                    // Counter saturates at the terminal value while hold is high.
                    if (r_dwell == DWELL_LAST) begin
                        if (!hold) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_dwell <= r_dwell + 32'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_seg = seg_decode(r_buf[int'(r_scan_idx)*4 +: 4]);

`ifdef SEG_SRC_DP_EN
    assign w_dp_n = ({1'b0, r_cur_src} != r_scan_idx);
`else
    assign w_dp_n = 1'b1;
`endif

    // Free-running scan; anode and cathode come from the same index in the
    // same register stage, so they can never be misaligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_anodo    <= 8'hFF;
            r_catodo   <= 8'hFF;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt <= '0;
                r_scan_idx <= r_scan_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 32'd1;
            end
            r_anodo  <= ~(8'b1 << r_scan_idx);
            r_catodo <= {w_dp_n, w_seg[6:0]};
        end
    end

    assign cur_src = r_cur_src;
    assign busy    = r_busy;
    assign anodo   = r_anodo;
    assign catodo  = r_catodo;

endmodule
